// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, used by both my_uart (tx)
// and my_uart_rx.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 10;   // 10 MHz logic clock, 1 Mbaud

    typedef enum logic [2:0] {
        RX_WAIT_IDLE = 3'd0,
        RX_IDLE      = 3'd1,
        RX_START     = 3'd2,
        RX_DATA      = 3'd3,
        RX_STOP      = 3'd4
    } rx_state_t;

endpackage

// File: rtl/my_uart_rx_if.sv
// Receive-side bundle: serial line in, held byte plus status out to the consumer.
interface my_uart_rx_if;
    import uart_pkg::*;

    logic                      rx;
    logic                      byte_rd;
    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      byte_ready;
    logic                      frame_err;
    logic                      overrun;

    // slave: the receiver itself; master: whoever drives the line and reads bytes
    modport slave (
        input  rx,
        input  byte_rd,
        output rx_byte,
        output byte_ready,
        output frame_err,
        output overrun
    );

    modport master (
        output rx,
        output byte_rd,
        input  rx_byte,
        input  byte_ready,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; reset value is a parameter
// so idle-high lines (uart rx) and idle-low lines (disc_trig) both come up quiet.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/my_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off the start-bit edge, one-byte holding
// register with byte_ready/byte_rd handshake, frame error pulse, sticky overrun.
module my_uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic        clk,
    input  logic        reset,
    my_uart_rx_if.slave bus
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int BIDX_W  = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_state_t                 state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [BIDX_W-1:0]         bit_idx_reg;
    logic [UART_DATA_BITS-1:0] shreg_reg;
    logic [UART_DATA_BITS-1:0] rx_byte_reg;
    logic                      byte_ready_reg;
    logic                      frame_err_reg;
    logic                      overrun_reg;

    // Resets to 1 so the line looks idle while reset is held.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RX_WAIT_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shreg_reg      <= '0;
            rx_byte_reg    <= '0;
            byte_ready_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;

            // Consumer read; a byte load below in the same cycle takes precedence.
            if (bus.byte_rd && byte_ready_reg) begin
                byte_ready_reg <= 1'b0;
                overrun_reg    <= 1'b0;
            end

            case (state_reg)
                RX_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_reg <= RX_IDLE;
                    end
                end

                RX_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                    end
                end

                RX_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                RX_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shreg_reg <= {rx_s, shreg_reg[UART_DATA_BITS-1:1]};
                        if (bit_idx_reg == LAST_BIT) begin
                            state_reg <= RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIDX_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                RX_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            rx_byte_reg    <= shreg_reg;
                            byte_ready_reg <= 1'b1;
                            // Simultaneous read consumes the old byte: no overrun.
                            if (byte_ready_reg) begin
                                overrun_reg <= !bus.byte_rd;
                            end
                            state_reg <= RX_IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                default: state_reg <= RX_WAIT_IDLE;
            endcase
        end
    end

    assign bus.rx_byte    = rx_byte_reg;
    assign bus.byte_ready = byte_ready_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.overrun    = overrun_reg;

endmodule
